multicycle_control_fsm: RTL and testbench

Moore state machine that sequences the multi-cycle RISC-V datapath: fetch, decode, execute, memory and writeback over 3–5 clock cycles per instruction. It sits beside the combinational ALU decoder inside the controller. It takes the opcode from the instruction register and the ALU Zero flag, and drives every datapath enable and mux select. ImmSrc is decoded from the opcode with the same encoding the single-cycle decoder uses.

---
 rtl/multicycle_control_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore controller sequencing the multi-cycle RISC-V datapath
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       Illegal,
    output logic       Retire,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    state_t     r_state;
    state_t     w_next;
    logic       w_pcupdate;
    logic       w_branch;
    logic       w_adrsrc;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [2:0] w_immsrc;
    logic       w_illegal;
    logic       w_retire;
    logic       w_valid_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pcupdate  = 1'b0;
        w_branch    = 1'b0;
        w_adrsrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluop     = 2'b00;
        w_illegal   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_irwrite   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_pcupdate  = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
                case (Opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_LUI:       w_next = S_LUI;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                        w_retire  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_next    = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                w_next   = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
                w_retire    = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_EXECR: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU forms OldPC+4 for rd
                w_alusrca  = 2'b01;
                w_alusrcb  = 2'b10;
                w_pcupdate = 1'b1;
                w_next     = S_ALUWB;
            end
            S_BEQ: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b01;
                w_branch  = 1'b1;
                w_retire  = 1'b1;
            end
            S_LUI: begin
                w_resultsrc = 2'b11;
                w_regwrite  = 1'b1;
                w_retire    = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (Opcode)
            OP_SW:   w_immsrc = 3'b001;
            OP_BEQ:  w_immsrc = 3'b010;
            OP_JAL:  w_immsrc = 3'b011;
            OP_LUI:  w_immsrc = 3'b100;
            default: w_immsrc = 3'b000;
        endcase
    end

    assign w_valid_state = (r_state <= S_LUI);

    // Reset gates every output combinationally so nothing leaks before the flop clears
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        ImmSrc    = 3'b000;
        Illegal   = 1'b0;
        Retire    = 1'b0;
        State     = 4'd0;
        if (!reset) begin
            State = r_state;
            if (w_valid_state) begin
                PCWrite   = w_pcupdate | (w_branch & Zero);
                AdrSrc    = w_adrsrc;
                MemWrite  = w_memwrite;
                IRWrite   = w_irwrite;
                RegWrite  = w_regwrite;
                ResultSrc = w_resultsrc;
                ALUSrcA   = w_alusrca;
                ALUSrcB   = w_alusrcb;
                ALUOp     = w_aluop;
                ImmSrc    = w_immsrc;
                Illegal   = w_illegal;
                Retire    = w_retire;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized instruction-level check of the multi-cycle controller
module tb_multicycle_control_fsm;
    logic       clk;
    logic       reset;
    logic [6:0] Opcode;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal, Retire;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] State;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .Illegal(Illegal), .Retire(Retire), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_JAL = 4, C_BEQ = 5, C_LUI = 6, C_ILL = 7;

    function automatic int op_class(input logic [6:0] op);
        case (op)
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b1101111: return C_JAL;
            7'b1100011: return C_BEQ;
            7'b0110111: return C_LUI;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic int instr_len(input int c);
        case (c)
            C_LW:              return 5;
            C_SW, C_R, C_I, C_JAL: return 4;
            C_BEQ, C_LUI:      return 3;
            default:           return 2;
        endcase
    endfunction

    // Third-cycle state and beyond, as listed in the instruction walkthroughs
    function automatic logic [3:0] seq_state(input int c, input int k);
        if (k == 0) return 4'd0;
        if (k == 1) return 4'd1;
        case (c)
            C_LW:    return (k == 2) ? 4'd2 : (k == 3) ? 4'd3 : 4'd4;
            C_SW:    return (k == 2) ? 4'd2 : 4'd5;
            C_R:     return (k == 2) ? 4'd6 : 4'd7;
            C_I:     return (k == 2) ? 4'd8 : 4'd7;
            C_JAL:   return (k == 2) ? 4'd9 : 4'd7;
            C_BEQ:   return 4'd10;
            default: return 4'd11;
        endcase
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op_class(op))
            C_SW:    return 3'b001;
            C_BEQ:   return 3'b010;
            C_JAL:   return 3'b011;
            C_LUI:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [18:0] observed();
        return {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal, Retire};
    endfunction

    task automatic check_idle(input string name);
        n_tests++;
        if (observed() !== 19'd0) begin
            n_fail++;
            $display("FAIL %s: outputs=%h required=0", name, observed());
        end
    endtask

    // Called just after a negedge while the DUT sits in FETCH; returns at a negedge.
    // zsel 0/1 forces Zero in BEQ, 2 randomizes it; abort_k asserts reset in that cycle.
    task automatic run_instr(input logic [6:0] op, input int zsel, input int abort_k);
        int c, n;
        logic [3:0] st;
        logic       last, pcw, adr, rsamp;
        logic [1:0] rs, sa, sb, aop;
        logic [18:0] exp_v;
        c = op_class(op);
        n = instr_len(c);
        for (int k = 0; k < n; k++) begin
            rsamp = (k == 1) || (k == 2 && (c == C_LW || c == C_SW));
            if (k == 0)      Opcode = op;
            else if (!rsamp) Opcode = 7'($urandom);
            if (c == C_BEQ && k == 2 && zsel < 2) Zero = zsel[0];
            else                                  Zero = 1'($urandom);
            #1;
            st   = seq_state(c, k);
            last = (k == n - 1);
            pcw  = (k == 0) || (c == C_JAL && k == 2) || (c == C_BEQ && k == 2 && Zero);
            adr  = (c == C_LW || c == C_SW) && k == 3;
            rs   = (k == 0) ? 2'b10 : (c == C_LW && k == 4) ? 2'b01 : (c == C_LUI && k == 2) ? 2'b11 : 2'b00;
            sa   = (k == 1 || (c == C_JAL && k == 2)) ? 2'b01 :
                   (k == 2 && c != C_LUI) ? 2'b10 : 2'b00;
            sb   = (k == 0 || (c == C_JAL && k == 2)) ? 2'b10 :
                   (k == 1 || (k == 2 && (c == C_LW || c == C_SW || c == C_I))) ? 2'b01 : 2'b00;
            aop  = (k == 2 && c == C_BEQ) ? 2'b01 : (k == 2 && (c == C_R || c == C_I)) ? 2'b10 : 2'b00;
            exp_v = {st, pcw, adr, (last && c == C_SW), (k == 0),
                     (last && (c == C_LW || c == C_R || c == C_I || c == C_JAL || c == C_LUI)),
                     rs, sa, sb, aop, (c == C_ILL && k == 1), last};
            n_tests++;
            if (observed() !== exp_v) begin
                n_fail++;
                $display("FAIL ctrl op=%b cyc=%0d zero=%b: outputs=%h required=%h", op, k, Zero, observed(), exp_v);
            end
            n_tests++;
            if (ImmSrc !== exp_imm(Opcode)) begin
                n_fail++;
                $display("FAIL immsrc op=%b: got=%b required=%b", Opcode, ImmSrc, exp_imm(Opcode));
            end
            if (k == abort_k) begin
                #1 reset = 1'b1;
                #1 check_idle("abort_immediate");
                @(negedge clk);
                #1 check_idle("abort_held");
                reset = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Opcode = 7'b0000011;
        Zero = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 check_idle("reset_hold");
        end
        reset = 1'b0;
        run_instr(7'b0000011, 2, -1);
    endtask

    task automatic test_sw();
        run_instr(7'b0100011, 2, -1);
    endtask

    task automatic test_beq();
        run_instr(7'b1100011, 1, -1);
        run_instr(7'b1100011, 0, -1);
    endtask

    task automatic test_back_to_back();
        run_instr(7'b0110011, 2, -1);
        run_instr(7'b1101111, 2, -1);
        run_instr(7'b0110111, 2, -1);
    endtask

    task automatic test_illegal();
        run_instr(7'b1111111, 2, -1);
    endtask

    task automatic test_reset_abort();
        run_instr(7'b0100011, 2, 3);
        run_instr(7'b0010011, 2, -1);
    endtask

    task automatic test_random();
        logic [6:0] ops [8];
        logic [6:0] op;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1101111, 7'b1100011, 7'b0110111, 7'b0000000};
        for (int i = 0; i < 200; i++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 7'b0000000) op = 7'($urandom);
            run_instr(op, 2, -1);
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_beq();
        test_back_to_back();
        test_illegal();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
